// File: rtl/data_ram_dbg_port_if.sv
// Debug-link side of the data RAM debug port: command, write-data and
// read-data channels.
//
// Handshake rule for all three channels: a beat transfers on the rising
// clock edge where valid and ready are both high. Once valid is raised its
// payload stays stable until that edge. valid never waits on ready.
// ready may depend on valid.
interface data_ram_dbg_port_if #(
    parameter int LEN_W = 8
);
    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [29:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0]       cmd_be;
    // write data channel
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    // read data channel
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_data;
    logic             rd_last;

    // debug link: issues commands, supplies write data, consumes read data
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
        output wr_valid, wr_data,
        output rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );

    // access engine
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
        input  wr_valid, wr_data,
        input  rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/data_ram_dbg_port.sv
// Debug-side burst engine for port b of the dual-port data BRAM.
// Turns burst commands into word-address sequences and byte enables, and
// returns read data across the BRAM's one-cycle read latency with
// backpressure. Every output is a register.
// Optional beat counters are built when DATA_RAM_DBG_CNT_EN is defined.
// Otherwise wr_beats/rd_beats read as zero.
module data_ram_dbg_port #(
    parameter int LEN_W     = 8,
    parameter int VALID_LSB = 14,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    data_ram_dbg_port_if.slave dbg,
    output logic               busy,
    output logic               cmd_err,
    output logic [29:0]        addrb,
    output logic [31:0]        dinb,
    output logic [3:0]         web,
    input  logic [31:0]        doutb,
    output logic [CNT_W-1:0]   wr_beats,
    output logic [CNT_W-1:0]   rd_beats,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

    state_t           state;
    logic [29:0]      cur_addr;
    logic [LEN_W-1:0] remaining;
    logic [3:0]       be_q;
    logic             wr_hs;
    logic             rd_hs;

    // VALID_LSB counts byte-address bits, so the word-address check starts
    // two bits lower.
    function automatic logic out_of_range(input logic [29:0] a);
        return |a[29:VALID_LSB-2];
    endfunction

    assign wr_hs     = (state == WR) && dbg.wr_valid && dbg.wr_ready;
    assign rd_hs     = (state == RD_RESP) && dbg.rd_valid && dbg.rd_ready;
    assign state_dbg = state;

    // Burst sequencer: command capture, write beats, read issue/wait/respond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            be_q          <= '0;
            dbg.cmd_ready <= 1'b1;
            dbg.wr_ready  <= 1'b0;
            dbg.rd_valid  <= 1'b0;
            dbg.rd_last   <= 1'b0;
            dbg.rd_data   <= '0;
            busy          <= 1'b0;
            cmd_err       <= 1'b0;
            addrb         <= '0;
            dinb          <= '0;
            web           <= '0;
        end else begin
            // web is a single-cycle pulse; only a write handshake raises it
            web <= 4'b0;
            case (state)
                IDLE: begin
                    if (dbg.cmd_valid && dbg.cmd_ready) begin
                        cur_addr      <= dbg.cmd_addr;
                        remaining     <= dbg.cmd_len;
                        be_q          <= dbg.cmd_be;
                        cmd_err       <= 1'b0;
                        dbg.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (dbg.cmd_write) begin
                            state        <= WR;
                            dbg.wr_ready <= 1'b1;
                        end else begin
                            // present the first read address during RD_ISSUE
                            state <= RD_ISSUE;
                            addrb <= dbg.cmd_addr;
                        end
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        addrb    <= cur_addr;
                        dinb     <= dbg.wr_data;
                        web      <= be_q;
                        cur_addr <= cur_addr + 30'd1;
                        if (out_of_range(cur_addr)) begin
                            cmd_err <= 1'b1;
                        end
                        if (remaining == '0) begin
                            state         <= IDLE;
                            dbg.wr_ready  <= 1'b0;
                            dbg.cmd_ready <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    // addrb already holds cur_addr; the BRAM samples it at this edge
                    addrb <= cur_addr;
                    if (out_of_range(cur_addr)) begin
                        cmd_err <= 1'b1;
                    end
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    dbg.rd_data  <= doutb;
                    dbg.rd_valid <= 1'b1;
                    dbg.rd_last  <= (remaining == '0);
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (rd_hs) begin
                        dbg.rd_valid <= 1'b0;
                        dbg.rd_last  <= 1'b0;
                        if (remaining == '0) begin
                            state         <= IDLE;
                            dbg.cmd_ready <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            cur_addr  <= cur_addr + 30'd1;
                            addrb     <= cur_addr + 30'd1;
                            remaining <= remaining - LEN_W'(1);
                            state     <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DATA_RAM_DBG_CNT_EN
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    // Saturating beat counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_hs && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (rd_hs && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    assign wr_beats = wr_cnt;
    assign rd_beats = rd_cnt;
`else
    assign wr_beats = '0;
    assign rd_beats = '0;
`endif

endmodule

// File: tb/tb_data_ram_dbg_port.sv
// Directed bench for data_ram_dbg_port with a behavioural port-b BRAM
// (4K words, 1-cycle read latency, out-of-range reads return 0).
module tb_data_ram_dbg_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        cmd_err;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic [3:0]  web;
    logic [31:0] doutb;
    logic [15:0] wr_beats;
    logic [15:0] rd_beats;
    logic [2:0]  state_dbg;

    data_ram_dbg_port_if #(.LEN_W(8)) dbg ();

    data_ram_dbg_port #(.LEN_W(8), .VALID_LSB(14), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg       (dbg),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .addrb     (addrb),
        .dinb      (dinb),
        .web       (web),
        .doutb     (doutb),
        .wr_beats  (wr_beats),
        .rd_beats  (rd_beats),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model ----------------
    bit [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (addrb[29:12] == 18'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (web[i]) mem[addrb[11:0]][8*i +: 8] <= dinb[8*i +: 8];
            end
            doutb <= mem[addrb[11:0]];
        end else begin
            doutb <= 32'h0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- write scoreboard: {addr, data, be} ----------------
    logic [65:0] exp_q[$];
    int exp_wr = 0;
    int exp_rd = 0;

    always @(negedge clk) begin
        if (web != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("web_unexpected", {60'h0, web}, 64'h0);
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                check("web_addr", {34'h0, addrb}, {34'h0, e[65:36]});
                check("web_data", {32'h0, dinb}, {32'h0, e[35:4]});
                check("web_be", {60'h0, web}, {60'h0, e[3:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] wbuf [0:7];
    logic [31:0] rbuf [0:7];

    task automatic send_cmd(input logic w, input logic [29:0] a, input logic [7:0] l, input logic [3:0] be);
        int t;
        @(negedge clk);
        dbg.cmd_valid = 1'b1;
        dbg.cmd_write = w;
        dbg.cmd_addr  = a;
        dbg.cmd_len   = l;
        dbg.cmd_be    = be;
        t = 0;
        while (!dbg.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", {63'h0, dbg.cmd_ready}, 64'h1);
        @(negedge clk);
        dbg.cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [29:0] a, input logic [3:0] be, input int n);
        int t;
        send_cmd(1'b1, a, 8'(n - 1), be);
        for (int i = 0; i < n; i++) begin
            dbg.wr_valid = 1'b1;
            dbg.wr_data  = wbuf[i];
            t = 0;
            while (!dbg.wr_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("wr_ready", {63'h0, dbg.wr_ready}, 64'h1);
            exp_q.push_back({30'(a + 30'(i)), wbuf[i], be});
            exp_wr++;
            @(negedge clk);
        end
        dbg.wr_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [29:0] a, input int n, input int hold);
        int t;
        int prev;
        logic [31:0] d0;
        logic [29:0] a0;
        dbg.rd_ready = (hold == 0);
        send_cmd(1'b0, a, 8'(n - 1), 4'h0);
        prev = 0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!dbg.rd_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rd_valid", {63'h0, dbg.rd_valid}, 64'h1);
            check("rd_data", {32'h0, dbg.rd_data}, {32'h0, rbuf[i]});
            check("rd_last", {63'h0, dbg.rd_last}, {63'h0, (i == n - 1)});
            check("rd_addrb", {34'h0, addrb}, {34'h0, 30'(a + 30'(i))});
            if (i == 0) begin
                check("cmd_ready_busy", {63'h0, dbg.cmd_ready}, 64'h0);
                check("busy_rd", {63'h0, busy}, 64'h1);
            end
            if (i > 0 && hold == 0) check("rd_spacing", 64'(cyc - prev), 64'd3);
            prev = cyc;
            if (i == 0 && hold > 0) begin
                d0 = dbg.rd_data;
                a0 = addrb;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("hold_valid", {63'h0, dbg.rd_valid}, 64'h1);
                    check("hold_data", {32'h0, dbg.rd_data}, {32'h0, d0});
                    check("hold_addrb", {34'h0, addrb}, {34'h0, a0});
                end
                dbg.rd_ready = 1'b1;
            end
            exp_rd++;
            @(negedge clk);
        end
        dbg.rd_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n         = 1'b0;
        dbg.cmd_valid = 1'b0;
        dbg.cmd_write = 1'b0;
        dbg.cmd_addr  = '0;
        dbg.cmd_len   = '0;
        dbg.cmd_be    = '0;
        dbg.wr_valid  = 1'b0;
        dbg.wr_data   = '0;
        dbg.rd_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_cmd_ready", {63'h0, dbg.cmd_ready}, 64'h1);
        check("rst_wr_ready", {63'h0, dbg.wr_ready}, 64'h0);
        check("rst_rd_valid", {63'h0, dbg.rd_valid}, 64'h0);
        check("rst_rd_last", {63'h0, dbg.rd_last}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_cmd_err", {63'h0, cmd_err}, 64'h0);
        check("rst_web", {60'h0, web}, 64'h0);
        check("rst_addrb", {34'h0, addrb}, 64'h0);
        check("rst_dinb", {32'h0, dinb}, 64'h0);
        check("rst_rd_data", {32'h0, dbg.rd_data}, 64'h0);
        check("rst_state", {61'h0, state_dbg}, 64'h0);
        check("rst_wr_beats", {48'h0, wr_beats}, 64'h0);
        rst_n = 1'b1;

        // four-beat write at 0x10
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        wr_burst(30'h10, 4'hF, 4);
        check("wr_busy_done", {63'h0, busy}, 64'h0);
        check("wr_cmd_ready_done", {63'h0, dbg.cmd_ready}, 64'h1);
        check("wr_ready_done", {63'h0, dbg.wr_ready}, 64'h0);
        @(negedge clk);
        check("wr_pulses_left", 64'(exp_q.size()), 64'd0);

        // read back, full throughput
        rbuf[0] = 32'h11; rbuf[1] = 32'h22; rbuf[2] = 32'h33; rbuf[3] = 32'h44;
        rd_burst(30'h10, 4, 0);
        check("rd_cmd_err", {63'h0, cmd_err}, 64'h0);

        // byte-enable merge
        wbuf[0] = 32'h1234_5678;
        wr_burst(30'h20, 4'hF, 1);
        wbuf[0] = 32'hAABB_CCDD;
        wr_burst(30'h20, 4'b0010, 1);
        rbuf[0] = 32'h1234_CC78;
        rd_burst(30'h20, 1, 0);

        // backpressure on the first beat
        rbuf[0] = 32'h11; rbuf[1] = 32'h22;
        rd_burst(30'h10, 2, 5);

        // out-of-range start wrapping to word 0
        rbuf[0] = 32'h0; rbuf[1] = 32'h0;
        rd_burst(30'h3FFF_FFFF, 2, 0);
        check("oor_cmd_err", {63'h0, cmd_err}, 64'h1);

        // next accepted command clears the sticky error
        rbuf[0] = 32'h11;
        rd_burst(30'h10, 1, 0);
        check("err_cleared", {63'h0, cmd_err}, 64'h0);

`ifdef DATA_RAM_DBG_CNT_EN
        check("wr_beats", {48'h0, wr_beats}, 64'(exp_wr));
        check("rd_beats", {48'h0, rd_beats}, 64'(exp_rd));
`else
        check("wr_beats_off", {48'h0, wr_beats}, 64'h0);
        check("rd_beats_off", {48'h0, rd_beats}, 64'h0);
`endif

        // reset during beat 2 of a four-beat write at 0x40
        send_cmd(1'b1, 30'h40, 8'd3, 4'hF);
        dbg.wr_valid = 1'b1;
        dbg.wr_data  = 32'hA1;
        check("rst_wr_ready_b1", {63'h0, dbg.wr_ready}, 64'h1);
        exp_q.push_back({30'h40, 32'hA1, 4'hF});
        @(negedge clk);
        dbg.wr_data = 32'hA2;
        rst_n       = 1'b0;
        @(negedge clk);
        check("mid_rst_web", {60'h0, web}, 64'h0);
        check("mid_rst_cmd_ready", {63'h0, dbg.cmd_ready}, 64'h1);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        check("mid_rst_wr_ready", {63'h0, dbg.wr_ready}, 64'h0);
        check("mid_rst_state", {61'h0, state_dbg}, 64'h0);
        check("mid_rst_wr_beats", {48'h0, wr_beats}, 64'h0);
        check("mid_rst_rd_beats", {48'h0, rd_beats}, 64'h0);
        dbg.wr_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_mem40", {32'h0, mem[12'h040]}, 64'hA1);
        check("mid_rst_mem41", {32'h0, mem[12'h041]}, 64'h0);
        check("mid_rst_pulses_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard stop in case a wait is not bounded as intended
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
